// File: rtl/gbt_link_reset_sequencer_pkg.sv
// Shared types for the GBT link reset sequencer: FSM state encoding,
// timer/counter widths and a saturating increment helper.
package MCPkg;

  typedef enum logic [1:0] {
    ST_PLL_RST    = 2'd0,
    ST_LOCK_WAIT  = 2'd1,
    ST_READY_WAIT = 2'd2,
    ST_LINKED     = 2'd3
  } t_link_seq_state;

  localparam int unsigned TIMER_W = 12;
  localparam int unsigned RETRY_W = 8;

  // Bit positions of the asynchronous status inputs in the synchroniser bank
  localparam int unsigned SYNC_LOS    = 0;
  localparam int unsigned SYNC_LOCKED = 1;
  localparam int unsigned SYNC_RX_RDY = 2;
  localparam int unsigned SYNC_TX_RDY = 3;
  localparam int unsigned SYNC_N      = 4;

  function automatic logic [TIMER_W-1:0] timer_sat_inc(input logic [TIMER_W-1:0] value);
    return (value == {TIMER_W{1'b1}}) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/gbt_link_reset_sequencer_sync_2ff.sv
// Single-bit two-flop synchroniser with asynchronous active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic q_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b0;
      q_reg    <= 1'b0;
    end else begin
      meta_reg <= d;
      q_reg    <= meta_reg;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/gbt_link_reset_sequencer.sv
// Brings up a GBT link: pulses the 40 MHz PLL reset, waits for lock, releases
// the GBT core and declares the link up once rx/tx ready have been stable.
module gbt_link_reset_sequencer
  import MCPkg::*;
#(
  parameter int unsigned G_PLL_RST_MS  = 2,
  parameter int unsigned G_LOCK_TO_MS  = 100,
  parameter int unsigned G_READY_TO_MS = 2400,
  parameter int unsigned G_HOLD_MS     = 10
) (
  input  logic               clk_ik,
  input  logic               rst_n_ia,
  input  logic               tick_1ms_i,
  input  logic               los_i,
  input  logic               pll_locked_i,
  input  logic               rx_ready_i,
  input  logic               tx_ready_i,
  input  logic               force_reset_i,
  output logic               pll_reset_o,
  output logic               gbt_reset_o,
  output logic               link_up_o,
  output logic [1:0]         state_o,
  output logic [RETRY_W-1:0] retry_cnt_o,
  output logic               lol_evt_o
);

  // Terminal timer values: the N-th tick after entry arrives while the timer holds N-1
  localparam logic [TIMER_W-1:0] PLL_RST_LAST  = TIMER_W'(G_PLL_RST_MS - 1);
  localparam logic [TIMER_W-1:0] LOCK_TO_LAST  = TIMER_W'(G_LOCK_TO_MS - 1);
  localparam logic [TIMER_W-1:0] READY_TO_LAST = TIMER_W'(G_READY_TO_MS - 1);
  localparam logic [TIMER_W-1:0] HOLD_LAST     = TIMER_W'(G_HOLD_MS - 1);

  logic [SYNC_N-1:0] async_in;
  logic [SYNC_N-1:0] sync_in;

  assign async_in[SYNC_LOS]    = los_i;
  assign async_in[SYNC_LOCKED] = pll_locked_i;
  assign async_in[SYNC_RX_RDY] = rx_ready_i;
  assign async_in[SYNC_TX_RDY] = tx_ready_i;

  generate
    for (genvar gi = 0; gi < SYNC_N; gi++) begin : g_sync
      sync_2ff u_sync (
        .clk   (clk_ik),
        .rst_n (rst_n_ia),
        .d     (async_in[gi]),
        .q     (sync_in[gi])
      );
    end
  endgenerate

  logic los;
  logic locked;
  logic ready_ok;

  assign los      = sync_in[SYNC_LOS];
  assign locked   = sync_in[SYNC_LOCKED];
  assign ready_ok = sync_in[SYNC_RX_RDY] & sync_in[SYNC_TX_RDY];

  t_link_seq_state    state_reg, state_next;
  logic [TIMER_W-1:0] timer_reg, timer_next;
  logic [TIMER_W-1:0] ready_to_reg, ready_to_next;
  logic [RETRY_W-1:0] retry_reg, retry_next;
  logic               pll_reset_reg, pll_reset_next;
  logic               gbt_reset_reg, gbt_reset_next;
  logic               link_up_reg, link_up_next;
  logic               lol_evt_reg, lol_evt_next;
  logic               retry_inc;

  always_comb begin
    state_next    = state_reg;
    timer_next    = timer_reg;
    ready_to_next = ready_to_reg;
    retry_inc     = 1'b0;
    lol_evt_next  = 1'b0;

    if (force_reset_i) begin
      state_next = ST_PLL_RST;
    end else begin
      unique case (state_reg)
        ST_PLL_RST: begin
          if (los) begin
            timer_next = '0;
          end else if (tick_1ms_i) begin
            if (timer_reg == PLL_RST_LAST) state_next = ST_LOCK_WAIT;
            else                           timer_next = timer_sat_inc(timer_reg);
          end
        end

        ST_LOCK_WAIT: begin
          if (los) begin
            state_next = ST_PLL_RST;
            retry_inc  = 1'b1;
          end else if (tick_1ms_i && timer_reg == LOCK_TO_LAST) begin
            state_next = ST_PLL_RST;
            retry_inc  = 1'b1;
          end else if (locked) begin
            state_next = ST_READY_WAIT;
          end else if (tick_1ms_i) begin
            timer_next = timer_sat_inc(timer_reg);
          end
        end

        // timer_reg is the stability (hold) timer here; ready_to_reg runs from entry
        ST_READY_WAIT: begin
          if (los) begin
            state_next = ST_PLL_RST;
            retry_inc  = 1'b1;
          end else if (tick_1ms_i && ready_to_reg == READY_TO_LAST) begin
            state_next = ST_PLL_RST;
            retry_inc  = 1'b1;
          end else if (ready_ok && tick_1ms_i && timer_reg == HOLD_LAST) begin
            state_next = ST_LINKED;
          end else begin
            if (tick_1ms_i) ready_to_next = timer_sat_inc(ready_to_reg);
            if (!ready_ok)       timer_next = '0;
            else if (tick_1ms_i) timer_next = timer_sat_inc(timer_reg);
          end
        end

        ST_LINKED: begin
          if (los || !ready_ok || !locked) begin
            state_next   = ST_PLL_RST;
            retry_inc    = 1'b1;
            lol_evt_next = 1'b1;
          end else if (tick_1ms_i) begin
            timer_next = timer_sat_inc(timer_reg);
          end
        end

        default: state_next = ST_PLL_RST;
      endcase
    end

    // Every state entry (including a forced re-entry of PLL_RST) starts both timers afresh
    if (force_reset_i || state_next != state_reg) begin
      timer_next    = '0;
      ready_to_next = '0;
    end

    retry_next = (retry_inc && retry_reg != {RETRY_W{1'b1}}) ? retry_reg + 1'b1 : retry_reg;

    pll_reset_next = (state_next == ST_PLL_RST);
    gbt_reset_next = (state_next == ST_PLL_RST) || (state_next == ST_LOCK_WAIT);
    link_up_next   = (state_next == ST_LINKED);
  end

  always_ff @(posedge clk_ik or negedge rst_n_ia) begin
    if (!rst_n_ia) begin
      state_reg     <= ST_PLL_RST;
      timer_reg     <= '0;
      ready_to_reg  <= '0;
      retry_reg     <= '0;
      pll_reset_reg <= 1'b1;
      gbt_reset_reg <= 1'b1;
      link_up_reg   <= 1'b0;
      lol_evt_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      ready_to_reg  <= ready_to_next;
      retry_reg     <= retry_next;
      pll_reset_reg <= pll_reset_next;
      gbt_reset_reg <= gbt_reset_next;
      link_up_reg   <= link_up_next;
      lol_evt_reg   <= lol_evt_next;
    end
  end

  assign pll_reset_o = pll_reset_reg;
  assign gbt_reset_o = gbt_reset_reg;
  assign link_up_o   = link_up_reg;
  assign state_o     = state_reg;
  assign retry_cnt_o = retry_reg;
  assign lol_evt_o   = lol_evt_reg;

endmodule

// File: doc/gbt_link_reset_sequencer.md
GBT_LINK_RESET_SEQUENCER -- requirements
Module: gbt_link_reset_sequencer

Interface
REQ-001 SHALL have parameter G_PLL_RST_MS, default 2, PLL reset pulse width in 1 ms ticks.
REQ-002 SHALL have parameter G_LOCK_TO_MS, default 100, PLL lock timeout in ticks.
REQ-003 SHALL have parameter G_READY_TO_MS, default 2400, GBT ready timeout in ticks.
REQ-004 SHALL have parameter G_HOLD_MS, default 10, ticks rx/tx ready must stay stable before link declared up.
REQ-005 SHALL have port clk_ik, in, 1, single clock (120 MHz domain); one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port rst_n_ia, in, 1, asynchronous active-low reset.
REQ-007 SHALL have port tick_1ms_i, in, 1, one-cycle enable pulse every 1 ms (clk_ik domain).
REQ-008 SHALL have ports los_i, pll_locked_i, rx_ready_i, tx_ready_i, in, 1 each, asynchronous status from SFP, 40 MHz PLL and GBT core.
REQ-009 SHALL have port force_reset_i, in, 1, one-cycle software restart request (clk_ik domain).
REQ-010 SHALL have ports pll_reset_o and gbt_reset_o, out, 1 each, active-high resets to 40 MHz PLL and GBT core.
REQ-011 SHALL have port link_up_o, out, 1, link established.
REQ-012 SHALL have ports state_o, out, 2, current state; retry_cnt_o, out, 8, restart counter; lol_evt_o, out, 1, one-cycle pulse on loss of established link.

Function
REQ-013 SHALL pass los_i, pll_locked_i, rx_ready_i, tx_ready_i through 2-FF synchronisers; all decisions use synchronised values (2-cycle input latency).
REQ-014 SHALL implement FSM: PLL_RST=0, LOCK_WAIT=1, READY_WAIT=2, LINKED=3.
REQ-015 SHALL keep a 12-bit ms timer, cleared on every state entry, incremented on tick_1ms_i, saturating at 4095.
REQ-016 PLL_RST: pll_reset_o=1, gbt_reset_o=1; go to LOCK_WAIT on the G_PLL_RST_MS-th tick after entry; while los high, timer held at 0.
REQ-017 LOCK_WAIT: pll_reset_o=0, gbt_reset_o=1; locked -> READY_WAIT; G_LOCK_TO_MS-th tick without lock -> PLL_RST, retry_cnt+1.
REQ-018 READY_WAIT: gbt_reset_o=0; timer cleared on any cycle rx_ready&tx_ready is low; G_HOLD_MS-th consecutive tick with both high -> LINKED.
REQ-019 READY_WAIT: second timer (12-bit, same rules) counts from entry; G_READY_TO_MS-th tick -> PLL_RST, retry_cnt+1.
REQ-020 LINKED: link_up_o=1; drop of rx_ready, tx_ready or pll_locked -> PLL_RST, lol_evt_o=1 for one cycle, retry_cnt+1.
REQ-021 los high in LOCK_WAIT, READY_WAIT or LINKED -> PLL_RST next cycle, retry_cnt+1 (lol_evt_o only from LINKED).
REQ-022 force_reset_i in any state -> PLL_RST next cycle with timers cleared; does not increment retry_cnt.
REQ-023 Priority per cycle: force_reset_i > los > lock/ready loss > timeout > progress condition; tick coinciding with a transition is discarded.
REQ-024 retry_cnt_o SHALL saturate at 255 and be cleared only by reset.
REQ-025 All outputs SHALL be registered; state change visible on outputs one cycle after the deciding synchronised input.

Reset
REQ-026 On rst_n_ia low, immediately: state PLL_RST, pll_reset_o=1, gbt_reset_o=1, link_up_o=0, state_o=0, retry_cnt_o=0, lol_evt_o=0, timers and synchronisers 0.
REQ-027 Reset mid-operation SHALL abort any state; after release the sequence restarts from PLL_RST with full G_PLL_RST_MS width.

Structure
REQ-028 State enum t_link_seq_state and state encodings SHALL live in MCPkg; parameters stay local to the module.
REQ-029 One sub-module, sync_2ff (1-bit 2-FF synchroniser with async active-low reset), instantiated four times.

Verification (bench params: PLL_RST 2, LOCK_TO 5, READY_TO 10, HOLD 3; tick every 10 cycles)
REQ-030 Nominal: lock after 1 tick in LOCK_WAIT, ready high -> LINKED 3 ticks after entering READY_WAIT, link_up_o=1, retry_cnt_o=0.
REQ-031 Lock timeout: pll_locked_i held 0 -> PLL_RST after 5th tick, retry_cnt_o=1, pll_reset_o high for exactly 2 ticks again.
REQ-032 Ready glitch: rx_ready low for 1 cycle at tick 2 of HOLD -> hold restarts, LINKED reached 3 ticks after glitch; 10-tick timeout still from entry.
REQ-033 Link loss: in LINKED drop tx_ready_i -> lol_evt_o single pulse 3 cycles later, state_o=0, retry_cnt_o increments.
REQ-034 force_reset_i and tick same cycle in READY_WAIT -> PLL_RST, retry_cnt_o unchanged; 300 forced LOS events -> retry_cnt_o=255.
REQ-035 Async reset asserted in LINKED mid-cycle -> all outputs at reset values before next clock edge.
